// File: rtl/alu_pkg.sv
// Shared definitions for the Y86 ALU scheduler.
// Function codes, FSM states and condition-code bit positions.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;
    localparam int CC_W  = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub/and/xor units muxed by fn.
// Also derives zero, sign and signed-overflow flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       fn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    logic [WIDTH-1:0] add_r;
    logic [WIDTH-1:0] sub_r;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] xor_r;
    logic             sa;
    logic             sb;

    assign add_r = a + b;
    assign sub_r = a - b;
    assign and_r = a & b;
    assign xor_r = a ^ b;
    assign sa    = a[WIDTH-1];
    assign sb    = b[WIDTH-1];

    // Select the unit output and its overflow rule
    always_comb begin
        r  = '0;
        of = 1'b0;
        unique case (fn)
            ALU_ADD: begin
                r  = add_r;
                of = (sa == sb) && (add_r[WIDTH-1] != sa);
            end
            ALU_SUB: begin
                r  = sub_r;
                of = (sa != sb) && (sub_r[WIDTH-1] != sa);
            end
            ALU_AND: r = and_r;
            ALU_XOR: r = xor_r;
        endcase
    end

    assign zf = (r == '0);
    assign sf = r[WIDTH-1];

endmodule

// File: rtl/alu_sched.sv
// Two-port round-robin scheduler around the shared ALU.
// Issues one op at a time, registers result and condition codes.
module alu_sched
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_fn,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_set_cc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_fn,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_set_cc,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        fn_q, fn_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              set_cc_q, set_cc_d;
    logic              id_q, id_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [WIDTH-1:0]  resp_result_q, resp_result_d;
    logic [CC_W-1:0]   cc_q, cc_d;

    logic              any_req;
    logic              grant_id;
    logic [WIDTH-1:0]  core_r;
    logic              core_zf;
    logic              core_sf;
    logic              core_of;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .fn (fn_q),
        .a  (a_q),
        .b  (b_q),
        .r  (core_r),
        .zf (core_zf),
        .sf (core_sf),
        .of (core_of)
    );

    assign any_req  = req0_valid | req1_valid;
    assign grant_id = (req0_valid & req1_valid) ? ~last_grant_q
                                                : req1_valid;

    // Arbitration, operand capture and FSM next-state
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        fn_d          = fn_q;
        a_d           = a_q;
        b_d           = b_q;
        set_cc_d      = set_cc_q;
        id_d          = id_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        cc_d          = cc_q;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rst_n && any_req) begin
                    req0_ready   = ~grant_id;
                    req1_ready   = grant_id;
                    last_grant_d = grant_id;
                    id_d         = grant_id;
                    fn_d         = grant_id ? req1_fn     : req0_fn;
                    a_d          = grant_id ? req1_a      : req0_a;
                    b_d          = grant_id ? req1_b      : req0_b;
                    set_cc_d     = grant_id ? req1_set_cc : req0_set_cc;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_result_d = core_r;
                resp_id_d     = id_q;
                resp_valid_d  = 1'b1;
                if (set_cc_q) begin
                    cc_d[CC_ZF] = core_zf;
                    cc_d[CC_SF] = core_sf;
                    cc_d[CC_OF] = core_of;
                end
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            fn_q          <= ALU_ADD;
            a_q           <= '0;
            b_q           <= '0;
            set_cc_q      <= 1'b0;
            id_q          <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            cc_q          <= CC_W'(1) << CC_ZF;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            fn_q          <= fn_d;
            a_q           <= a_d;
            b_q           <= b_d;
            set_cc_q      <= set_cc_d;
            id_q          <= id_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            cc_q          <= cc_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign cc_zf       = cc_q[CC_ZF];
    assign cc_sf       = cc_q[CC_SF];
    assign cc_of       = cc_q[CC_OF];

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched.
// One task per scenario; expected values computed by hand.
module tb_alu_sched;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [1:0]   req0_fn = 2'd0;
    logic [W-1:0] req0_a = '0;
    logic [W-1:0] req0_b = '0;
    logic         req0_set_cc = 1'b0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [1:0]   req1_fn = 2'd0;
    logic [W-1:0] req1_a = '0;
    logic [W-1:0] req1_b = '0;
    logic         req1_set_cc = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic         resp_id;
    logic [W-1:0] resp_result;
    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;

    int checks = 0;
    int errors = 0;

    alu_sched #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_fn     (req0_fn),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_set_cc (req0_set_cc),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_fn     (req1_fn),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_set_cc (req1_set_cc),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .cc_zf       (cc_zf),
        .cc_sf       (cc_sf),
        .cc_of       (cc_of)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        tick;
        tick;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        checks++;
        if ({resp_valid, resp_id, resp_result} !== {1'b0, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL reset_resp: got v=%b id=%b r=%h expected 0", resp_valid, resp_id, resp_result);
        end
        checks++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            errors++;
            $display("FAIL reset_cc: got %b expected 100", {cc_zf, cc_sf, cc_of});
        end
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_xor_port0;
        req0_fn = 2'd3;
        req0_a = 64'b001010;
        req0_b = 64'b001111;
        req0_set_cc = 1'b1;
        req0_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL xor_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        tick;
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({req0_ready, resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL xor_exec: got rdy=%b v=%b expected 0 0", req0_ready, resp_valid);
        end
        tick;
        checks++;
        if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 64'd5}) begin
            errors++;
            $display("FAIL xor_resp: got v=%b id=%b r=%h expected 1 0 5", resp_valid, resp_id, resp_result);
        end
        checks++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
            errors++;
            $display("FAIL xor_cc: got %b expected 000", {cc_zf, cc_sf, cc_of});
        end
        tick;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL xor_done: got v=%b expected 0", resp_valid);
        end
    endtask

    task automatic test_sub_of_port1;
        req1_fn = 2'd1;
        req1_a = 64'h8000_0000_0000_0000;
        req1_b = 64'd1;
        req1_set_cc = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL sub_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        tick;
        req1_valid = 1'b0;
        tick;
        checks++;
        if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF}) begin
            errors++;
            $display("FAIL sub_resp: got v=%b id=%b r=%h expected 1 1 7fffffffffffffff", resp_valid, resp_id, resp_result);
        end
        checks++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b001) begin
            errors++;
            $display("FAIL sub_cc: got %b expected 001", {cc_zf, cc_sf, cc_of});
        end
        tick;
    endtask

    task automatic test_tie;
        logic         e0;
        logic         e1;
        int           k;
        logic [W-1:0] exp_r;
        req0_fn = 2'd0;
        req0_a = 64'd1;
        req0_b = 64'd1;
        req0_set_cc = 1'b0;
        req1_fn = 2'd0;
        req1_a = 64'd2;
        req1_b = 64'd2;
        req1_set_cc = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            k = c / 3;
            e0 = (c % 3 == 0) && (k % 2 == 0);
            e1 = (c % 3 == 0) && (k % 2 == 1);
            checks++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                errors++;
                $display("FAIL tie_grant c=%0d: got %b expected %b", c, {req0_ready, req1_ready}, {e0, e1});
            end
            if (c % 3 == 2) begin
                exp_r = (k % 2 == 1) ? 64'd4 : 64'd2;
                checks++;
                if ({resp_valid, resp_id, resp_result} !== {1'b1, (k % 2 == 1), exp_r}) begin
                    errors++;
                    $display("FAIL tie_resp c=%0d: got v=%b id=%b r=%h expected 1 %0d %h", c, resp_valid, resp_id, resp_result, k % 2, exp_r);
                end
            end
            tick;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        resp_ready = 1'b0;
        req0_fn = 2'd2;
        req0_a = 64'hF0;
        req0_b = 64'h3C;
        req0_set_cc = 1'b1;
        req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: got %b expected 1", req0_ready);
        end
        tick;
        req0_valid = 1'b0;
        req1_fn = 2'd0;
        req1_valid = 1'b1;
        tick;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({resp_valid, resp_id, resp_result, req0_ready, req1_ready} !== {1'b1, 1'b0, 64'h30, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold i=%0d: got v=%b id=%b r=%h rdy=%b%b expected 1 0 30 00", i, resp_valid, resp_id, resp_result, req0_ready, req1_ready);
            end
            tick;
        end
        checks++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin
            errors++;
            $display("FAIL bp_cc: got %b expected 000", {cc_zf, cc_sf, cc_of});
        end
        resp_ready = 1'b1;
        tick;
        checks++;
        if ({resp_valid, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got v=%b rdy1=%b expected 0 1", resp_valid, req1_ready);
        end
        req1_valid = 1'b0;
        tick;
    endtask

    task automatic test_set_cc;
        req0_fn = 2'd0;
        req0_a = 64'd5;
        req0_b = 64'hFFFF_FFFF_FFFF_FFFB;
        req0_set_cc = 1'b0;
        req0_valid = 1'b1;
        tick;
        req0_valid = 1'b0;
        tick;
        checks++;
        if ({resp_result, cc_zf, cc_sf, cc_of} !== {64'd0, 3'b000}) begin
            errors++;
            $display("FAIL nocc_add: got r=%h cc=%b expected 0 000", resp_result, {cc_zf, cc_sf, cc_of});
        end
        tick;
        req0_set_cc = 1'b1;
        req0_valid = 1'b1;
        tick;
        req0_valid = 1'b0;
        tick;
        checks++;
        if ({resp_result, cc_zf, cc_sf, cc_of} !== {64'd0, 3'b100}) begin
            errors++;
            $display("FAIL cc_add: got r=%h cc=%b expected 0 100", resp_result, {cc_zf, cc_sf, cc_of});
        end
        tick;
        req0_a = 64'h7FFF_FFFF_FFFF_FFFF;
        req0_b = 64'd1;
        req0_valid = 1'b1;
        tick;
        req0_valid = 1'b0;
        tick;
        checks++;
        if ({resp_result, cc_zf, cc_sf, cc_of} !== {64'h8000_0000_0000_0000, 3'b011}) begin
            errors++;
            $display("FAIL add_of: got r=%h cc=%b expected 8000000000000000 011", resp_result, {cc_zf, cc_sf, cc_of});
        end
        tick;
    endtask

    task automatic test_reset_mid;
        req1_fn = 2'd0;
        req1_a = 64'd1;
        req1_b = 64'd1;
        req1_set_cc = 1'b1;
        req1_valid = 1'b1;
        tick;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        tick;
        checks++;
        if ({resp_valid, resp_id, resp_result} !== {1'b0, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL mid_resp: got v=%b id=%b r=%h expected 0", resp_valid, resp_id, resp_result);
        end
        checks++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            errors++;
            $display("FAIL mid_cc: got %b expected 100", {cc_zf, cc_sf, cc_of});
        end
        rst_n = 1'b1;
        tick;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle: got v=%b expected 0", resp_valid);
        end
        req0_fn = 2'd0;
        req0_a = 64'd3;
        req0_b = 64'd4;
        req0_set_cc = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mid_rr: got %b expected 10", {req0_ready, req1_ready});
        end
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
        checks++;
        if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 64'd7}) begin
            errors++;
            $display("FAIL mid_op: got v=%b id=%b r=%h expected 1 0 7", resp_valid, resp_id, resp_result);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_xor_port0;
        test_sub_of_port1;
        test_tie;
        test_backpressure;
        test_set_cc;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler and sequencer for the shared 64-bit Y86 ALU (add/sub/and/xor units). Accepts operations from the execute stage (port 0) and the address/stack-pointer path (port 1), arbitrates round-robin, and drives one operation at a time through the ALU. Registers the result and, on request, updates the ZF/SF/OF condition-code register consumed by branch and cmov logic.

## Interface
- WIDTH, 64, datapath width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- req0_valid  in  1  port-0 operation offered
- req0_ready  out  1  port-0 operation accepted this cycle
- req0_fn  in  2  function: 0 ADD, 1 SUB, 2 AND, 3 XOR
- req0_a, req0_b  in  WIDTH  operands (signed)
- req0_set_cc  in  1  update condition codes with this result
- req1_valid, req1_ready, req1_fn, req1_a, req1_b, req1_set_cc: same as port 0
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  port that issued the result
- resp_result  out  WIDTH  registered ALU result
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one, assert its reqN_ready combinationally for one cycle, latch fn/a/b/set_cc/id, go to EXEC. Otherwise stay.
- Arbitration: round-robin on a last_grant bit. Both valid: grant the port not granted last. One valid: grant it. last_grant resets to 1, so port 0 wins the first tie.
- EXEC: ALU evaluates latched operands. Register result into resp_result and id into resp_id. Set resp_valid. If set_cc, load CCs. Go to RESP.
- RESP: hold resp_* stable until resp_valid & resp_ready, then clear resp_valid and go to IDLE.
- ReqN_ready is never asserted outside IDLE. The non-granted port keeps waiting, and its valid/operands must stay stable.
- Arithmetic is modulo 2^WIDTH. ADD r=a+b. SUB r=a-b. AND r=a&b. XOR r=a^b.
- ZF=(r==0). SF=r[WIDTH-1].
- OF for ADD: a,b same sign and r sign differs from a. OF for SUB: a,b differ in sign and r sign differs from a. OF=0 for AND and XOR.
- CCs change only in EXEC with set_cc=1. Otherwise they hold.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_id 0, resp_result 0, cc_zf 1, cc_sf 0, cc_of 0, req*_ready 0, last_grant 1.
- Latency: accept edge to resp_valid high is 2 cycles (IDLE→EXEC→RESP). CCs become visible on the same edge as resp_valid.
- Minimum issue interval is 3 cycles, achieved when resp_ready is held high. The next acceptance is in the cycle after the response handshake.
- If resp_ready is low, RESP holds indefinitely and the outputs stay unchanged.
- Reset asserted in any state returns all outputs to reset values on the next edge. An in-flight op is discarded and its CC update is suppressed if it has not yet occurred.
- A requester that drops valid in the same cycle as ready is still accepted, because the handshake is sampled on that edge.

## Structure
- Shared package alu_pkg holds:
  - function codes ALU_ADD/ALU_SUB/ALU_AND/ALU_XOR (2-bit);
  - the state enum IDLE/EXEC/RESP;
  - the CC bit-index constants.
- Sub-module alu_core is purely combinational: fn, a, b → r, zf, sf, of. It instantiates the existing 64-bit add, sub, and, xor units and muxes their outputs by fn.
- alu_sched contains the arbiter, FSM, operand latches, result register and CC register.

## Test plan
- XOR on port 0 only: a=0b001010, b=0b001111, set_cc=1 → req0_ready one cycle, resp_result=5, resp_id=0, ZF=0, SF=0, OF=0, resp_valid 2 cycles after accept.
- SUB overflow on port 1: a=0x8000000000000000, b=1, set_cc=1 → result 0x7FFFFFFFFFFFFFFF, OF=1, SF=0, ZF=0.
- Tie: both ports valid every cycle after reset, resp_ready=1 → grants alternate 0,1,0,1. Each port is accepted every 6 cycles.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid → resp_* stable, no req*_ready asserted. Resp_ready=1 → IDLE next cycle.
- set_cc=0: ADD a=5, b=-5 → result 0 while CCs keep their previous values (ZF unchanged). Repeating with set_cc=1 gives ZF=1.
- Reset mid-op: assert rst_n=0 in EXEC with set_cc=1 → next cycle resp_valid=0, CCs at reset values, state IDLE.
